// File: rtl/servo_pkg.sv
// Shared timing defaults, command record and width clamp for the servo PWM bank.
package servo_pkg;

    localparam int unsigned DEF_PERIOD_CYC = 2000000;
    localparam int unsigned DEF_MIN_CYC    = 70000;
    localparam int unsigned DEF_MAX_W      = 200000;
    localparam int unsigned DEF_INIT_W     = 100000;
    localparam int unsigned DEF_STEP_W     = 48000;

    // Sized for the largest bank (16 channels) and any width up to 32 bits.
    typedef struct packed {
        logic [3:0]  ch;
        logic [31:0] width;
    } servo_cmd_t;

    function automatic logic [31:0] clamp_w(input logic [31:0] w, input logic [31:0] max_w);
        return (w > max_w) ? max_w : w;
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: target/active widths, frame-boundary update (optionally slew limited via
// SERVO_SLEW_EN), registered pulse compare and busy flag; both outputs lag their inputs by 1 cycle.
module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int unsigned MIN_CYC = DEF_MIN_CYC,
    parameter int unsigned MAX_W   = DEF_MAX_W,
    parameter int unsigned INIT_W  = DEF_INIT_W,
    parameter int unsigned STEP_W  = DEF_STEP_W,
    parameter int          CNT_W   = 21,
    parameter int          W_W     = 18
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] frame_cnt,
    input  logic             frame_tick,
    input  logic             load,
    input  logic [W_W-1:0]   load_width,
    output logic             pwm,
    output logic             busy
);

`ifdef SERVO_SLEW_EN
    localparam bit SLEW_ON = 1'b1;
`else
    localparam bit SLEW_ON = 1'b0;
`endif
    // Without slew the limit is MAX_W: every legal move then completes in one frame.
    localparam int unsigned STEP_LIM = SLEW_ON ? STEP_W : MAX_W;

    logic [W_W-1:0] target;
    logic [W_W-1:0] active;
    logic [W_W-1:0] next_w;
    logic [W_W:0]   diff;

    always_comb begin
        next_w = target;
        diff   = '0;
        if (target >= active) begin
            diff = {1'b0, target} - {1'b0, active};
            if (32'(diff) > STEP_LIM)
                next_w = active + W_W'(STEP_LIM);
        end else begin
            diff = {1'b0, active} - {1'b0, target};
            if (32'(diff) > STEP_LIM)
                next_w = active - W_W'(STEP_LIM);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            target <= W_W'(INIT_W);
            active <= W_W'(INIT_W);
            pwm    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            if (load)
                target <= load_width;
            if (frame_tick)
                active <= next_w;
            pwm  <= (32'(frame_cnt) < (MIN_CYC + 32'(active)));
            busy <= (active != target);
        end
    end

endmodule

// File: rtl/servo_pwm_bank.sv
// N-channel servo PWM bank with shared frame counter; outputs registered, 1-cycle latency.
// Commands accepted every cycle once out of reset (cmd_ready never drops); optional SERVO_SLEW_EN.
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int unsigned MIN_CYC    = DEF_MIN_CYC,
    parameter int unsigned MAX_W      = DEF_MAX_W,
    parameter int unsigned INIT_W     = DEF_INIT_W,
    parameter int unsigned STEP_W     = DEF_STEP_W,
    localparam int         CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int         W_W        = $clog2(MAX_W + 1)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [CH_W-1:0] cmd_ch,
    input  logic [W_W-1:0]  cmd_width,
    output logic            cmd_err,
    output logic [N_CH-1:0] pwm_out,
    output logic [N_CH-1:0] busy,
    output logic            frame_tick
);

    localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

    logic [CNT_W-1:0] frame_cnt;
    servo_cmd_t       cmd;
    logic             accept;
    logic             ch_ok;
    logic [W_W-1:0]   load_width;

    assign frame_tick = (frame_cnt == CNT_W'(PERIOD_CYC - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            frame_cnt <= '0;
        else if (frame_tick)
            frame_cnt <= '0;
        else
            frame_cnt <= frame_cnt + 1'b1;
    end

    always_comb begin
        cmd.ch    = 4'(cmd_ch);
        cmd.width = 32'(cmd_width);
    end

    assign accept     = cmd_valid && cmd_ready;
    assign ch_ok      = ({28'd0, cmd.ch} < N_CH);
    assign load_width = W_W'(clamp_w(cmd.width, MAX_W));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_ready <= 1'b1;
            cmd_err   <= accept && !ch_ok;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        servo_pwm_channel #(
            .MIN_CYC (MIN_CYC),
            .MAX_W   (MAX_W),
            .INIT_W  (INIT_W),
            .STEP_W  (STEP_W),
            .CNT_W   (CNT_W),
            .W_W     (W_W)
        ) u_ch (
            .clock      (clock),
            .reset_n    (reset_n),
            .frame_cnt  (frame_cnt),
            .frame_tick (frame_tick),
            .load       (accept && ch_ok && (cmd.ch == 4'(g))),
            .load_width (load_width),
            .pwm        (pwm_out[g]),
            .busy       (busy[g])
        );
    end

endmodule
